// File: rtl/gpio_input_conditioner_pkg.sv
// Shared GPIO input definitions: channel counts, debounce default
// and the pshIn field offsets also used by software headers.
package defines;

    localparam int unsigned GPIO_WIDTH           = 64;
    localparam int unsigned GPIO_NSW             = 4;
    localparam int unsigned GPIO_NPB             = 4;
    localparam int unsigned GPIO_DEBOUNCE_CYCLES = 1000000;

    localparam int unsigned PSH_LVL_LSB = 0;
    localparam int unsigned PSH_EVT_LSB = GPIO_NPB;

    function automatic int unsigned dbc_cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_input_conditioner_debounce_cell.sv
// One raw pin: two-flop synchroniser followed by a stable-count
// debouncer exposing the accepted level and a rising-accept strobe.
module debounce_cell
    import defines::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_q,
    output logic o_rise
);

    localparam int unsigned CW = dbc_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_q;
    logic [CW-1:0] r_cnt;
    logic          w_expire;

    assign w_expire = (r_s2 != r_q) && (r_cnt == LAST);
    assign o_q      = r_q;
    assign o_rise   = w_expire & r_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Any return of s2 to the accepted level drops the pending change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= 1'b0;
            r_cnt <= '0;
        end else if (r_s2 == r_q) begin
            r_cnt <= '0;
        end else if (w_expire) begin
            r_q   <= r_s2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// Switch/pushbutton conditioner: per-pin debounce, sticky press
// events, and packing into full-width swIn/pshIn read words.
module gpio_input_conditioner
    import defines::*;
#(
    parameter int unsigned WIDTH           = GPIO_WIDTH,
    parameter int unsigned NSW             = GPIO_NSW,
    parameter int unsigned NPB             = GPIO_NPB,
    parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NSW-1:0]   sw_raw,
    input  logic [NPB-1:0]   psh_raw,
    input  logic [NPB-1:0]   evt_clr,
    output logic [WIDTH-1:0] swIn,
    output logic [WIDTH-1:0] pshIn
);

    localparam int unsigned LVL_LSB = PSH_LVL_LSB;
    localparam int unsigned EVT_LSB = PSH_LVL_LSB + NPB;

    logic [NSW-1:0] w_sw_q;
    logic [NSW-1:0] w_unused_sw_rise;
    logic [NPB-1:0] w_pb_q;
    logic [NPB-1:0] w_pb_rise;
    logic [NPB-1:0] r_evt;

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk    (clk),
            .reset_n(reset_n),
            .i_raw  (sw_raw[g]),
            .o_q    (w_sw_q[g]),
            .o_rise (w_unused_sw_rise[g])
        );
    end

    for (genvar g = 0; g < NPB; g++) begin : g_pb
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk    (clk),
            .reset_n(reset_n),
            .i_raw  (psh_raw[g]),
            .o_q    (w_pb_q[g]),
            .o_rise (w_pb_rise[g])
        );
    end

    // A press accepted on the same edge as a clear keeps the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evt <= '0;
        end else begin
            r_evt <= w_pb_rise | (r_evt & ~evt_clr);
        end
    end

    always_comb begin
        swIn                   = '0;
        swIn[NSW-1:0]          = w_sw_q;
        pshIn                  = '0;
        pshIn[LVL_LSB +: NPB]  = w_pb_q;
        pshIn[EVT_LSB +: NPB]  = r_evt;
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES=4:
// a change first sampled at edge t0 is accepted at edge t0+5.
module tb_gpio_input_conditioner;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   sw_raw;
    logic [3:0]   psh_raw;
    logic [3:0]   evt_clr;
    logic [W-1:0] swIn;
    logic [W-1:0] pshIn;

    int total = 0;
    int bad   = 0;

    gpio_input_conditioner #(
        .WIDTH          (W),
        .NSW            (4),
        .NPB            (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .sw_raw (sw_raw),
        .psh_raw(psh_raw),
        .evt_clr(evt_clr),
        .swIn   (swIn),
        .pshIn  (pshIn)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        sw_raw  = 4'hF;
        psh_raw = 4'hF;
        evt_clr = 4'h0;
        reset_n = 1'b0;
        step(3);
        chk("rst_sw", swIn, 64'h0);
        chk("rst_psh", pshIn, 64'h0);

        reset_n = 1'b1;
        step(5);
        chk("rel_sw_early", swIn, 64'h0);
        chk("rel_psh_early", pshIn, 64'h0);
        step(1);
        chk("rel_sw", swIn, 64'hF);
        chk("rel_psh", pshIn, 64'hFF);

        reset_n = 1'b0;
        #1;
        chk("async_rst_sw", swIn, 64'h0);
        chk("async_rst_psh", pshIn, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sw", swIn, 64'h0);
        chk("mid_rst_psh", pshIn, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step(5);
        chk("rerun_sw_early", swIn, 64'h0);
        chk("rerun_psh_early", pshIn, 64'h0);
        step(1);
        chk("rerun_sw", swIn, 64'hF);
        chk("rerun_psh", pshIn, 64'hFF);

        reset_n = 1'b0;
        sw_raw  = 4'h0;
        psh_raw = 4'h0;
        step(2);
        reset_n = 1'b1;
        step(2);

        sw_raw = 4'h1;
        step(3);
        sw_raw = 4'h0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("glitch", swIn, 64'h0);
        end

        psh_raw = 4'h2;
        step(5);
        chk("press_early", pshIn, 64'h00);
        step(1);
        chk("press", pshIn, 64'h22);
        psh_raw = 4'h0;
        step(5);
        chk("release_early", pshIn, 64'h22);
        step(1);
        chk("release", pshIn, 64'h20);

        evt_clr = 4'h2;
        step(1);
        evt_clr = 4'h0;
        chk("clear", pshIn, 64'h00);

        psh_raw = 4'h2;
        step(5);
        evt_clr = 4'h2;
        step(1);
        evt_clr = 4'h0;
        chk("set_wins", pshIn, 64'h22);
        evt_clr = 4'h2;
        step(1);
        evt_clr = 4'h0;
        chk("clear_held", pshIn, 64'h02);

        for (int i = 0; i < 16; i++) begin
            psh_raw[2] = ~i[0];
            step(1);
            chk("bounce", pshIn, 64'h02);
        end
        psh_raw[2] = 1'b1;
        step(5);
        chk("bounce_settle_early", pshIn, 64'h02);
        step(1);
        chk("bounce_settle", pshIn, 64'h46);
        evt_clr = 4'h4;
        step(1);
        evt_clr = 4'h0;
        step(8);
        chk("bounce_single_evt", pshIn, 64'h06);

        reset_n = 1'b0;
        sw_raw  = 4'h0;
        psh_raw = 4'h0;
        step(2);
        reset_n = 1'b1;
        step(2);
        sw_raw  = 4'hA;
        psh_raw = 4'h5;
        step(5);
        chk("par_sw_early", swIn, 64'h0);
        chk("par_psh_early", pshIn, 64'h0);
        step(1);
        chk("par_sw", swIn, 64'hA);
        chk("par_psh", pshIn, 64'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
